// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial receive framer.
package serial_rx_pkg;

    localparam int unsigned DEFAULT_WIDTH        = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the clk domain.
module sync_2ff #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_framer.sv
// UART-style receiver: start bit, WIDTH data bits LSB first, optional even
// parity bit (macro SERIAL_RX_PARITY_EN), stop bit. Good frames update
// data_out with a one-cycle wr_en; bad frames pulse an error strobe instead.
module serial_rx_framer
    import serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             wr_en,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int unsigned      CNT_W     = cnt_width(CLKS_PER_BIT);
    localparam int unsigned      IDX_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
    logic [WIDTH-1:0]   shift_q, shift_nxt;
    logic               rx_s, rx_prev;
    logic               wr_c, ferr_c, perr_c;
`ifdef SERIAL_RX_PARITY_EN
    logic               par_bad, par_bad_nxt;
`endif

    sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            rx_prev <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift_q <= shift_nxt;
            rx_prev <= rx_s;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    // Next-state, bit timing and shift register update.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_q;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_nxt = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // Falling edge only; a held-low line keeps rx_prev at 0.
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
`ifdef SERIAL_RX_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_q[WIDTH-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_nxt = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_nxt   = PARITY;
`else
                        state_nxt   = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = (rx_s != (^shift_q));
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is caught.
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame verdict at the stop-bit sample; framing error outranks parity.
    always_comb begin
        wr_c   = 1'b0;
        ferr_c = 1'b0;
        perr_c = 1'b0;
        if (state == STOP && cnt == BIT_LAST) begin
            if (!rx_s) begin
                ferr_c = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            end else if (par_bad) begin
                perr_c = 1'b1;
`endif
            end else begin
                wr_c = 1'b1;
            end
        end
    end

    // Registered outputs; data_out only moves on a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            wr_en      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (wr_c) begin
                data_out <= shift_q;
            end
            wr_en      <= wr_c;
            frame_err  <= ferr_c;
            parity_err <= perr_c;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_rx_framer.sv
// Directed bench for serial_rx_framer (WIDTH=8, CLKS_PER_BIT=16).
// Build with SERIAL_RX_PARITY_EN defined to exercise the parity frames.
module tb_serial_rx_framer;

    localparam int unsigned CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       wr_en;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int wr_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    logic wr_prev = 1'b0;
    logic busy_after_wr = 1'b1;
    logic [7:0] wr_data_q[$];
    int wr_time_q[$];

    serial_rx_framer #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .wr_en      (wr_en),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_prev) busy_after_wr = busy;
        wr_prev = wr_en;
        if (wr_en) begin
            wr_cnt = wr_cnt + 1;
            wr_data_q.push_back(data_out);
            wr_time_q.push_back(cyc);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a falling clock edge; ends with rx high.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    int w0, f0;

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_data_out", 32'(data_out), 32'h0);
        check_eq("rst_wr_en", 32'(wr_en), 32'h0);
        check_eq("rst_frame_err", 32'(frame_err), 32'h0);
        check_eq("rst_parity_err", 32'(parity_err), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Good frame 0xA5
        w0 = wr_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(10);
        check_eq("a5_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check_eq("a5_data_out", 32'(data_out), 32'hA5);
        check_eq("a5_frame_err", 32'(ferr_cnt - f0), 32'd0);
        check_eq("a5_busy_after_wr", 32'(busy_after_wr), 32'h0);

        // False start: line low for 3 cycles only
        w0 = wr_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("fs_busy_mid", 32'(busy), 32'h1);
        idle(30);
        check_eq("fs_busy_end", 32'(busy), 32'h0);
        check_eq("fs_wr_pulses", 32'(wr_cnt - w0), 32'd0);
        check_eq("fs_frame_err", 32'(ferr_cnt - f0), 32'd0);
        check_eq("fs_data_out", 32'(data_out), 32'hA5);

        // 0x3C with a low stop bit
        w0 = wr_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(10);
        check_eq("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check_eq("ferr_wr_pulses", 32'(wr_cnt - w0), 32'd0);
        check_eq("ferr_data_out", 32'(data_out), 32'hA5);

        // Control: 0x3C with a good stop bit
        w0 = wr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        check_eq("ctl_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check_eq("ctl_data_out", 32'(data_out), 32'h3C);

        // Reset during data bit 4 of 0x5A
        w0 = wr_cnt;
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                #2 rst = 1'b0;
                #1;
                check_eq("arst_data_out", 32'(data_out), 32'h0);
                check_eq("arst_wr_en", 32'(wr_en), 32'h0);
                check_eq("arst_frame_err", 32'(frame_err), 32'h0);
                check_eq("arst_parity_err", 32'(parity_err), 32'h0);
                check_eq("arst_busy", 32'(busy), 32'h0);
            end
        join
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        check_eq("arst_no_strobe", 32'(wr_cnt - w0), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        check_eq("arst_rx_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check_eq("arst_rx_data_out", 32'(data_out), 32'h3C);

        // Back-to-back 0x00 then 0xFF
        wr_data_q.delete();
        wr_time_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(10);
        check_eq("b2b_count", 32'(wr_data_q.size()), 32'd2);
        if (wr_data_q.size() >= 2) begin
            check_eq("b2b_first", 32'(wr_data_q[0]), 32'h00);
            check_eq("b2b_second", 32'(wr_data_q[1]), 32'hFF);
            check_eq("b2b_spacing", 32'(wr_time_q[1] - wr_time_q[0]), 32'(FRAME_BITS * CPB));
        end
        check_eq("b2b_data_out", 32'(data_out), 32'hFF);

`ifdef SERIAL_RX_PARITY_EN
        // 0x07 with wrong parity bit (0), then correct (1)
        w0 = wr_cnt; f0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        check_eq("par_bad_perr", 32'(perr_cnt - f0), 32'd1);
        check_eq("par_bad_wr", 32'(wr_cnt - w0), 32'd0);
        check_eq("par_bad_data_out", 32'(data_out), 32'hFF);
        w0 = wr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        check_eq("par_ok_wr", 32'(wr_cnt - w0), 32'd1);
        check_eq("par_ok_data_out", 32'(data_out), 32'h07);
        check_eq("par_total_perr", 32'(perr_cnt), 32'd1);
`else
        check_eq("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
